// File: rtl/aes_pkg.sv
// Shared AES decrypt-path types, the inverse S-box and GF(2^8) helpers
// used by the inverse round datapath.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam aes_byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Source byte index for each InvShiftRows output byte.
  localparam int unsigned INV_SR_SRC [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

  function automatic aes_byte_t gf_mul2(input aes_byte_t a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t acc;
    aes_byte_t x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = gf_mul2(x);
    end
    return acc;
  endfunction

  function automatic aes_state_t inv_shift_rows_f(input aes_state_t s);
    aes_state_t r;
    r = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      r[(15 - j) * 8 +: 8] = s[(15 - INV_SR_SRC[j]) * 8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_mix_column.sv
// InvMixColumns for one 32-bit column (row 0 in the top byte); purely combinational.
module inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  aes_byte_t a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign col_o[31:24] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
  assign col_o[23:16] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
  assign col_o[15:8]  = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
  assign col_o[7:0]   = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);

endmodule

// File: rtl/inv_round_unit.sv
// Two-stage pipelined AES inverse-cipher round with valid/ready on both sides.
// Optional output-stall counter enabled by defining INV_ROUND_STALL_CNT_EN.
module inv_round_unit
  import aes_pkg::*;
#(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
`ifdef INV_ROUND_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  aes_state_t s1_q, s2_q;
  logic       s1_last_q, s1_valid_q, s2_valid_q;
  aes_state_t sr_w, t_d, mix_w, s2_d;
  logic       s1_adv, s2_adv;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    sr_w = inv_shift_rows_f(state_in);
    t_d  = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      t_d[i * 8 +: 8] = INV_SBOX[sr_w[i * 8 +: 8]];
    end
    t_d = t_d ^ round_key;
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_mix_column u_mix (
      .col_i(s1_q[(3 - c) * 32 +: 32]),
      .col_o(mix_w[(3 - c) * 32 +: 32])
    );
  end

  assign s2_d = s1_last_q ? s1_q : mix_w;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q       <= '0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_q      <= t_d;
          s1_last_q <= last_round;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) s2_q <= s2_d;
      end
    end
  end

  assign state_out = s2_q;
  assign out_valid = s2_valid_q;
  assign busy      = s1_valid_q | s2_valid_q;

`ifdef INV_ROUND_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // Saturating: holds at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stall_cnt_q <= '0;
    end else if (s2_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inv_round_unit.sv
// Directed/scoreboarded bench for inv_round_unit with an independent AES inverse-round model.
module tb_inv_round_unit;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         last_round;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
`ifdef INV_ROUND_STALL_CNT_EN
  logic [3:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int send_stalls = 0;
  logic [127:0] exp_q[$];
  logic [7:0]   inv_sb [256];

  always #5 clk = ~clk;

`ifdef INV_ROUND_STALL_CNT_EN
  inv_round_unit #(.STALL_CNT_W(4)) dut (
`else
  inv_round_unit dut (
`endif
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .round_key(round_key), .last_round(last_round),
    .out_valid(out_valid), .out_ready(out_ready), .state_out(state_out),
    .busy(busy)
`ifdef INV_ROUND_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = a << 1;
      if (hi) a ^= 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // Forward S-box from first principles; the inverse table is built from it.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] r;
    if (x != 0)
      for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return r;
  endfunction

  function automatic logic [127:0] model_round(input logic [127:0] st, input logic [127:0] key, input logic last);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] o [16];
    logic [7:0] coef [4];
    logic [127:0] res;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 16; i++) b[i] = st[127 - 8 * i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[r + 4 * c] = inv_sb[b[r + 4 * ((c - r + 4) % 4)]] ^ key[127 - 8 * (r + 4 * c) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        o[r + 4 * c] = 8'h00;
        for (int k = 0; k < 4; k++) o[r + 4 * c] ^= gmul(coef[(k - r + 4) % 4], t[k + 4 * c]);
      end
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = last ? t[i] : o[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l, input logic [127:0] exp);
    int waited = 0;
    in_valid = 1'b1; state_in = s; round_key = k; last_round = l;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      send_stalls++;
      if (waited > 40) begin
        checks++; errors++;
        $error("FAIL send_timeout: observed=in_ready low for %0d cycles expected=accept", waited);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #2;
      n++;
    end
    chk({tag, "_drained"}, 128'(exp_q.size()), 128'd0);
    chk({tag, "_out_valid_idle"}, 128'(out_valid), 128'd0);
    chk({tag, "_busy_idle"}, 128'(busy), 128'd0);
  endtask

  // Output scoreboard and hold-while-stalled checker.
  logic         prev_stall = 1'b0;
  logic [127:0] prev_out = '0;
  always @(negedge clk) begin
    if (!n_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_data", state_out, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL unexpected_out: observed=%h expected=no output", state_out);
        end else begin
          chk("scoreboard", state_out, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = state_out;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s, k;
    logic l;
    logic [127:0] held;
    for (int i = 0; i < 256; i++) inv_sb[sbox_fwd(8'(i))] = 8'(i);

    n_rst = 1'b0; in_valid = 1'b0; state_in = '0; round_key = '0; last_round = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
`ifdef INV_ROUND_STALL_CNT_EN
    chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
`endif
    n_rst = 1'b1;
    @(posedge clk); #1;

    // 1: final round, known vector, latency 2
    send(128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f, 1'b1,
         128'h00112233445566778899aabbccddeeff);
    idle();
    chk("lat_cycle1_out_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    chk("lat_cycle2_out_valid", 128'(out_valid), 128'd1);
    drain("t1");

    // 2: mix path with all-zero state and key
    send('0, '0, 1'b0, {16{8'h52}});
    idle();
    drain("t2");

    // 3: streaming at full rate
    send_stalls = 0;
    for (int i = 0; i < 8; i++) begin
      s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
      send(s, k, l, model_round(s, k, l));
    end
    idle();
    chk("stream_in_ready_drops", 128'(send_stalls), 128'd0);
    drain("t3");

    // 4: backpressure
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = rand128(); k = rand128();
      send(s, k, 1'b0, model_round(s, k, 1'b0));
    end
    idle();
    held = state_out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 128'(in_ready), 128'd0);
      chk("bp_busy", 128'(busy), 128'd1);
    end
    chk("bp_state_out_stable", state_out, held);
    @(posedge clk); #1;
    out_ready = 1'b1;
    s = rand128(); k = rand128();
    send(s, k, 1'b1, model_round(s, k, 1'b1));
    idle();
    drain("t4");

    // 3b: random backpressure while streaming
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          s = rand128(); k = rand128(); l = 1'($urandom_range(0, 1));
          send(s, k, l, model_round(s, k, l));
        end
        idle();
      end
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain("t3b");

    // 5: reset with both stages full
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s = rand128(); k = rand128();
      send(s, k, 1'b0, model_round(s, k, 1'b0));
    end
    idle();
    chk("pre_rst_busy", 128'(busy), 128'd1);
    chk("pre_rst_in_ready", 128'(in_ready), 128'd0);
    #2;
    n_rst = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_state_out", state_out, 128'd0);
    @(posedge clk); #3;
    n_rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    s = rand128(); k = rand128();
    send(s, k, 1'b0, model_round(s, k, 1'b0));
    idle();
    drain("t5");

`ifdef INV_ROUND_STALL_CNT_EN
    // 6: stall counter saturation
    chk("stall_cnt_start", 128'(stall_cnt), 128'd0);
    out_ready = 1'b0;
    s = rand128(); k = rand128();
    send(s, k, 1'b1, model_round(s, k, 1'b1));
    idle();
    repeat (20) @(posedge clk);
    #1;
    chk("stall_cnt_sat", 128'(stall_cnt), 128'd15);
    @(posedge clk); #1;
    chk("stall_cnt_nowrap", 128'(stall_cnt), 128'd15);
    out_ready = 1'b1;
    drain("t6");
    chk("stall_cnt_kept", 128'(stall_cnt), 128'd15);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
